// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial unsigned subtractor sequencer
//
// Purpose:
//   Latches two WIDTH-bit operands on an accepted start and subtracts them
//   LSB-first, one bit per clock, through two chained half-subtractor cells.
//   The difference and final borrow are presented at completion and held
//   until the next completion.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start_in  in   request, sampled only in IDLE
//   a_in      in   [WIDTH] minuend, sampled with an accepted start
//   b_in      in   [WIDTH] subtrahend, sampled with an accepted start
//   busy_out  out  high while bits are being processed
//   done_out  out  one-cycle completion pulse
//   d_out     out  [WIDTH] (a - b) mod 2^WIDTH
//   b_out     out  final borrow, 1 iff a < b

module serial_sub_half (
  input  logic a_in,
  input  logic b_in,
  output logic d_out,
  output logic b_out
);
  assign d_out = a_in ^ b_in;
  assign b_out = ~a_in & b_in;
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] d_out,
  output logic             b_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               bout_q, bout_d;

  // Full-subtract bit built from two half-subtractor stages.
  logic hs1_d, hs1_b, dbit, hs2_b, br_next;

  serial_sub_half u_hs1 (
    .a_in  (sa_q[0]),
    .b_in  (sb_q[0]),
    .d_out (hs1_d),
    .b_out (hs1_b)
  );

  serial_sub_half u_hs2 (
    .a_in  (hs1_d),
    .b_in  (br_q),
    .d_out (dbit),
    .b_out (hs2_b)
  );

  assign br_next = hs1_b | hs2_b;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    bout_d  = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_SHIFT;
          sa_d    = a_in;
          sb_d    = b_in;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Result fills from the MSB side so the LSB-first bits land in place
        // after WIDTH shifts.
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {dbit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          dout_d  = {dbit, res_q[WIDTH-1:1]};
          bout_d  = br_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign d_out    = dout_q;
  assign b_out    = bout_q;

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial N-bit unsigned subtractor sequencer built around the team's 1-bit half-subtractor cell: difference = a ^ b, borrow = ~a & b.
- Latches two WIDTH-bit operands on a start request and steps them LSB-first through a borrow-chained 1-bit subtract stage, one bit per clock.
- Presents the WIDTH-bit difference and the final borrow with a start/busy/done handshake.
- Sits between a requesting controller and any datapath needing low-area subtraction.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  minuend; sampled with an accepted start_in.
- b_in  input  WIDTH  subtrahend; sampled with an accepted start_in.
- busy_out  output  1  high while bits are being processed.
- done_out  output  1  one-cycle completion pulse.
- d_out  output  WIDTH  difference (a - b) mod 2^WIDTH.
- b_out  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Reset (rst_n low, takes effect immediately, independent of clk):
  - state = IDLE.
  - busy_out = 0, done_out = 0, d_out = 0, b_out = 0.
  - Internal shift registers, borrow register and bit counter cleared.
- Reset asserted mid-operation aborts the operation. No done_out is produced and there is no partial result on d_out. The block resumes in IDLE on the first clk edge after rst_n rises.
- State machine:
  - IDLE -> SHIFT: start_in = 1 at edge k. On that edge, a_in/b_in are latched into shift registers sa/sb, borrow register br = 0, counter = 0, busy_out = 1.
  - SHIFT: each edge processes bit 0 of sa/sb:
    - dbit = sa[0] ^ sb[0] ^ br.
    - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br), i.e. two half-subtractor stages ORed.
    - dbit is shifted into the result register from the MSB side; sa and sb shift right by one.
    - counter increments.
  - SHIFT -> DONE: on edge k+WIDTH, which processes the last bit (counter = WIDTH-1):
    - d_out takes the completed result; b_out takes br_next.
    - busy_out = 0, done_out = 1.
  - DONE -> IDLE: unconditional on the next edge; done_out returns to 0.
- Latency: done_out is high in the cycle following edge k+WIDTH, i.e. WIDTH cycles after the accepting edge. Minimum start-to-start spacing is WIDTH+2 cycles.
- d_out and b_out change only at the SHIFT->DONE edge (or on reset). They hold their value until the next completion, including throughout the next operation's SHIFT phase.
- start_in is ignored during SHIFT and DONE; no queuing. A start_in held high through DONE is accepted on the first IDLE edge.
- a_in and b_in are don't-care except on the accepting edge. Changing them during SHIFT has no effect.
- Wrap-around: the result is modulo 2^WIDTH, and b_out flags underflow.
- busy_out and done_out are never high simultaneously.

Test Plan:
- WIDTH=8, a_in=0x5A, b_in=0x3C, start 1 cycle -> busy_out high 8 cycles; done_out single pulse 8 cycles after accept; d_out=0x1E, b_out=0.
- a_in=0x00, b_in=0x01 -> d_out=0xFF, b_out=1. Then a_in=0xFF, b_in=0xFF -> d_out=0x00, b_out=0. Then a_in=0x80, b_in=0x7F -> d_out=0x01, b_out=0.
- Start with 0x10-0x01; pulse start_in with a_in=0xAA, b_in=0x55 at cycle 3 of SHIFT -> second start ignored; result 0x0F, b_out=0; exactly one done_out pulse.
- start_in held high continuously with operands fixed at 0x20/0x30 -> accepts every WIDTH+2 cycles; each completion gives d_out=0xF0, b_out=1; d_out stable between completions.
- Load 0x33-0x11, then drop rst_n at SHIFT cycle 4 for 2 cycles -> all outputs 0 immediately; no done_out. A new start with 0x09-0x04 then gives d_out=0x05, b_out=0 on schedule.
- Random regression, 1000 operand pairs -> d_out == (a-b) mod 256 and b_out == (a<b) for every completion.
